// File: rtl/logic_rs_gen2_if.sv
// Dispatch, CDB snoop and CDB result handshake bundle for the logic/shift reservation station.
interface logic_rs_gen2_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
);
    logic              in_rs_enable;
    logic [5:0]        in_operator_type;
    logic [DATA_W-1:0] in_val_1;
    logic [DATA_W-1:0] in_val_2;
    logic [TAG_W-1:0]  in_tag_1;
    logic [TAG_W-1:0]  in_tag_2;
    logic              out_rs_ready;
    logic [TAG_W-1:0]  out_rs_tag;
    logic              in_cdb_valid;
    logic [TAG_W-1:0]  in_cdb_tag;
    logic [DATA_W-1:0] in_cdb_val;
    logic              out_cdb_req;
    logic              in_cdb_grant;
    logic [TAG_W-1:0]  out_cdb_tag;
    logic [DATA_W-1:0] out_cdb_val;
    logic              out_icc_valid;
    logic [3:0]        out_icc_flags;

    modport master (
        output in_rs_enable, in_operator_type, in_val_1, in_val_2, in_tag_1, in_tag_2,
        output in_cdb_valid, in_cdb_tag, in_cdb_val, in_cdb_grant,
        input  out_rs_ready, out_rs_tag, out_cdb_req, out_cdb_tag, out_cdb_val,
        input  out_icc_valid, out_icc_flags
    );

    modport slave (
        input  in_rs_enable, in_operator_type, in_val_1, in_val_2, in_tag_1, in_tag_2,
        input  in_cdb_valid, in_cdb_tag, in_cdb_val, in_cdb_grant,
        output out_rs_ready, out_rs_tag, out_cdb_req, out_cdb_tag, out_cdb_val,
        output out_icc_valid, out_icc_flags
    );
endinterface

// File: rtl/logic_rs_gen2.sv
// Reservation station with a single-cycle logic/shift unit, CDB snooping and a req/grant result port.
// Define LOGIC_RS_ICC_EN to generate and present ICC flags for the _CC opcodes.
module logic_rs_gen2 #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned RS_ID  = 2
) (
    input  logic           clk,
    input  logic           rst,
    logic_rs_gen2_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned SH_W  = $clog2(DATA_W);
    localparam logic [TAG_W-1:0] INVALID_TAG = {TAG_W{1'b1}};

    localparam logic [5:0] OP_AND  = 6'h01;
    localparam logic [5:0] OP_OR   = 6'h02;
    localparam logic [5:0] OP_XOR  = 6'h03;
    localparam logic [5:0] OP_ANDN = 6'h05;
    localparam logic [5:0] OP_ORN  = 6'h06;
    localparam logic [5:0] OP_XNOR = 6'h07;
    localparam logic [5:0] OP_SLL  = 6'h25;
    localparam logic [5:0] OP_SRL  = 6'h26;
    localparam logic [5:0] OP_SRA  = 6'h27;

    typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_DONE} state_e;

    // _CC logic ops fold onto their plain encodings; shift encodings pass through unchanged
    function automatic logic [5:0] base_op(input logic [5:0] op);
        base_op = {op[5], op[5] & op[4], op[3:0]};
    endfunction

    function automatic logic op_ok(input logic [5:0] op);
        case (base_op(op))
            OP_AND, OP_OR, OP_XOR, OP_ANDN, OP_ORN, OP_XNOR,
            OP_SLL, OP_SRL, OP_SRA: op_ok = 1'b1;
            default:                op_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] exec(input logic [5:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        logic [SH_W-1:0] sh;
        sh = b[SH_W-1:0];
        case (base_op(op))
            OP_AND:  exec = a & b;
            OP_ANDN: exec = a & ~b;
            OP_OR:   exec = a | b;
            OP_ORN:  exec = a | ~b;
            OP_XOR:  exec = a ^ b;
            OP_XNOR: exec = a ^ ~b;
            OP_SLL:  exec = a << sh;
            OP_SRL:  exec = a >> sh;
            OP_SRA:  exec = DATA_W'($signed(a) >>> sh);
            default: exec = '0;
        endcase
    endfunction

    function automatic logic [TAG_W-1:0] entry_tag(input logic [IDX_W-1:0] idx);
        entry_tag = TAG_W'((RS_ID << IDX_W) | 32'(idx));
    endfunction

    state_e            state_q [DEPTH];
    state_e            state_d [DEPTH];
    logic [5:0]        op_q    [DEPTH];
    logic [5:0]        op_d    [DEPTH];
    logic [DATA_W-1:0] v1_q    [DEPTH];
    logic [DATA_W-1:0] v1_d    [DEPTH];
    logic [DATA_W-1:0] v2_q    [DEPTH];
    logic [DATA_W-1:0] v2_d    [DEPTH];
    logic [TAG_W-1:0]  t1_q    [DEPTH];
    logic [TAG_W-1:0]  t1_d    [DEPTH];
    logic [TAG_W-1:0]  t2_q    [DEPTH];
    logic [TAG_W-1:0]  t2_d    [DEPTH];
    logic [DATA_W-1:0] res_q   [DEPTH];
    logic [DATA_W-1:0] res_d   [DEPTH];

    logic              free_any, rdy_any, done_any;
    logic [IDX_W-1:0]  free_idx, rdy_idx, done_idx, sel_idx;
    logic              lock_q;
    logic [IDX_W-1:0]  lock_idx_q;
    logic              dis_acc;
    logic [DATA_W-1:0] dis_v1, dis_v2, iss_res;
    logic [TAG_W-1:0]  dis_t1, dis_t2;

    // Lowest-index search for allocation, issue and presentation
    always_comb begin
        free_any = 1'b0;
        rdy_any  = 1'b0;
        done_any = 1'b0;
        free_idx = '0;
        rdy_idx  = '0;
        done_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (state_q[i] == ST_FREE) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (state_q[i] == ST_READY) begin
                rdy_any = 1'b1;
                rdy_idx = IDX_W'(i);
            end
            if (state_q[i] == ST_DONE) begin
                done_any = 1'b1;
                done_idx = IDX_W'(i);
            end
        end
    end

    // A presented-but-ungranted result stays presented even if a lower index completes meanwhile
    assign sel_idx = lock_q ? lock_idx_q : done_idx;
    assign dis_acc = bus.in_rs_enable && free_any && op_ok(bus.in_operator_type);
    assign iss_res = exec(op_q[rdy_idx], v1_q[rdy_idx], v2_q[rdy_idx]);

    // Dispatch operands with same-cycle CDB bypass
    always_comb begin
        dis_v1 = bus.in_val_1;
        dis_t1 = bus.in_tag_1;
        dis_v2 = bus.in_val_2;
        dis_t2 = bus.in_tag_2;
        if (bus.in_cdb_valid && bus.in_tag_1 != INVALID_TAG && bus.in_tag_1 == bus.in_cdb_tag) begin
            dis_v1 = bus.in_cdb_val;
            dis_t1 = INVALID_TAG;
        end
        if (bus.in_cdb_valid && bus.in_tag_2 != INVALID_TAG && bus.in_tag_2 == bus.in_cdb_tag) begin
            dis_v2 = bus.in_cdb_val;
            dis_t2 = INVALID_TAG;
        end
    end

    // Per-entry next state: allocate, snoop, issue, release
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            state_d[i] = state_q[i];
            op_d[i]    = op_q[i];
            v1_d[i]    = v1_q[i];
            v2_d[i]    = v2_q[i];
            t1_d[i]    = t1_q[i];
            t2_d[i]    = t2_q[i];
            res_d[i]   = res_q[i];
            case (state_q[i])
                ST_FREE: begin
                    if (dis_acc && free_idx == IDX_W'(i)) begin
                        op_d[i]    = bus.in_operator_type;
                        v1_d[i]    = dis_v1;
                        v2_d[i]    = dis_v2;
                        t1_d[i]    = dis_t1;
                        t2_d[i]    = dis_t2;
                        state_d[i] = (dis_t1 == INVALID_TAG && dis_t2 == INVALID_TAG) ? ST_READY : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.in_cdb_valid && t1_q[i] != INVALID_TAG && t1_q[i] == bus.in_cdb_tag) begin
                        v1_d[i] = bus.in_cdb_val;
                        t1_d[i] = INVALID_TAG;
                    end
                    if (bus.in_cdb_valid && t2_q[i] != INVALID_TAG && t2_q[i] == bus.in_cdb_tag) begin
                        v2_d[i] = bus.in_cdb_val;
                        t2_d[i] = INVALID_TAG;
                    end
                    if (t1_d[i] == INVALID_TAG && t2_d[i] == INVALID_TAG) begin
                        state_d[i] = ST_READY;
                    end
                end
                ST_READY: begin
                    if (rdy_idx == IDX_W'(i)) begin
                        res_d[i]   = iss_res;
                        state_d[i] = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.in_cdb_grant && sel_idx == IDX_W'(i)) begin
                        state_d[i] = ST_FREE;
                    end
                end
                default: state_d[i] = ST_FREE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= ST_FREE;
                op_q[i]    <= '0;
                v1_q[i]    <= '0;
                v2_q[i]    <= '0;
                t1_q[i]    <= INVALID_TAG;
                t2_q[i]    <= INVALID_TAG;
                res_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= state_d[i];
                op_q[i]    <= op_d[i];
                v1_q[i]    <= v1_d[i];
                v2_q[i]    <= v2_d[i];
                t1_q[i]    <= t1_d[i];
                t2_q[i]    <= t2_d[i];
                res_q[i]   <= res_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= done_any & ~bus.in_cdb_grant;
            lock_idx_q <= sel_idx;
        end
    end

    assign bus.out_rs_ready = free_any;
    assign bus.out_rs_tag   = entry_tag(free_idx);
    assign bus.out_cdb_req  = done_any;
    assign bus.out_cdb_tag  = done_any ? entry_tag(sel_idx) : '0;
    assign bus.out_cdb_val  = done_any ? res_q[sel_idx] : '0;

`ifdef LOGIC_RS_ICC_EN
    logic       icc_cc_q [DEPTH];
    logic [3:0] icc_fl_q [DEPTH];

    // Flags {c,v,z,n} captured alongside the result at issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                icc_cc_q[i] <= 1'b0;
                icc_fl_q[i] <= '0;
            end
        end else if (rdy_any) begin
            icc_cc_q[rdy_idx] <= ~op_q[rdy_idx][5] & op_q[rdy_idx][4];
            icc_fl_q[rdy_idx] <= {2'b00, iss_res == '0, iss_res[DATA_W-1]};
        end
    end

    assign bus.out_icc_valid = done_any & icc_cc_q[sel_idx];
    assign bus.out_icc_flags = (done_any && icc_cc_q[sel_idx]) ? icc_fl_q[sel_idx] : 4'b0000;
`else
    assign bus.out_icc_valid = 1'b0;
    assign bus.out_icc_flags = 4'b0000;
`endif
endmodule

// File: tb/tb_logic_rs_gen2.sv
// Scoreboard bench for logic_rs_gen2: directed dispatch/snoop/grant sequences, monitor checks CDB results.
module tb_logic_rs_gen2;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 5;
    localparam int unsigned RS_ID  = 2;
    localparam logic [TAG_W-1:0] INV = 5'h1F;

    localparam logic [5:0] OP_AND   = 6'h01;
    localparam logic [5:0] OP_OR    = 6'h02;
    localparam logic [5:0] OP_XOR   = 6'h03;
    localparam logic [5:0] OP_ANDN  = 6'h05;
    localparam logic [5:0] OP_ORN   = 6'h06;
    localparam logic [5:0] OP_XNOR  = 6'h07;
    localparam logic [5:0] OP_ANDCC = 6'h11;
    localparam logic [5:0] OP_XORCC = 6'h13;
    localparam logic [5:0] OP_SLL   = 6'h25;
    localparam logic [5:0] OP_SRL   = 6'h26;
    localparam logic [5:0] OP_SRA   = 6'h27;
    localparam logic [5:0] OP_BAD   = 6'h3F;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
        logic              icc_v;
        logic [3:0]        icc_f;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic clk         = 1'b0;
    logic rst         = 1'b1;
    logic grant_en    = 1'b0;

    logic_rs_gen2_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    logic_rs_gen2 #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .RS_ID(RS_ID)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    assign bus.in_cdb_grant = grant_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // cc_fl = {icc_valid, flags} expected when ICC support is built in
    function automatic exp_t mk(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] val,
                                input logic [4:0] cc_fl);
        exp_t e;
        e.tag = tag;
        e.val = val;
        {e.icc_v, e.icc_f} = cc_fl;
`ifndef LOGIC_RS_ICC_EN
        {e.icc_v, e.icc_f} = 5'b0;
`endif
        return e;
    endfunction

    // Monitor: every granted presentation is compared against the oldest expectation
    always @(negedge clk) begin
        if (!rst && bus.out_cdb_req && bus.in_cdb_grant) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL mon_unexpected: actual tag=0x%0h val=0x%08h required no result",
                         bus.out_cdb_tag, bus.out_cdb_val);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mon_tag",   32'(bus.out_cdb_tag),   32'(e.tag));
                check("mon_val",   bus.out_cdb_val,        e.val);
                check("mon_icc_v", 32'(bus.out_icc_valid), 32'(e.icc_v));
                check("mon_icc_f", 32'(bus.out_icc_flags), 32'(e.icc_f));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                            input logic [4:0] t1, input logic [4:0] t2);
        bus.in_rs_enable     = 1'b1;
        bus.in_operator_type = op;
        bus.in_val_1         = v1;
        bus.in_val_2         = v2;
        bus.in_tag_1         = t1;
        bus.in_tag_2         = t2;
        cyc(1);
        bus.in_rs_enable     = 1'b0;
    endtask

    task automatic cdb(input logic [4:0] tag, input logic [31:0] val);
        bus.in_cdb_valid = 1'b1;
        bus.in_cdb_tag   = tag;
        bus.in_cdb_val   = val;
        cyc(1);
        bus.in_cdb_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.out_cdb_req) && n < 50) begin
            cyc(1);
            n++;
        end
        check("drain_pending", 32'(sb.size()), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bus.in_rs_enable     = 1'b0;
        bus.in_operator_type = '0;
        bus.in_val_1         = '0;
        bus.in_val_2         = '0;
        bus.in_tag_1         = INV;
        bus.in_tag_2         = INV;
        bus.in_cdb_valid     = 1'b0;
        bus.in_cdb_tag       = '0;
        bus.in_cdb_val       = '0;

        // Reset values
        cyc(2);
        @(negedge clk);
        check("rst_req",    32'(bus.out_cdb_req),   0);
        check("rst_tag",    32'(bus.out_cdb_tag),   0);
        check("rst_val",    bus.out_cdb_val,        0);
        check("rst_icc_v",  32'(bus.out_icc_valid), 0);
        check("rst_icc_f",  32'(bus.out_icc_flags), 0);
        check("rst_ready",  32'(bus.out_rs_ready),  1);
        check("rst_rs_tag", 32'(bus.out_rs_tag),    8);
        cyc(1);
        rst = 1'b0;

        // AND with both operands ready: req two cycles after dispatch
        grant_en = 1'b1;
        sb.push_back(mk(5'd8, 32'hF000_F000, 5'b0));
        dispatch(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, INV, INV);
        @(negedge clk); check("t1_req_early", 32'(bus.out_cdb_req), 0);
        @(negedge clk); check("t1_req_lat2",  32'(bus.out_cdb_req), 1);
        cyc(1);
        drain();

        // XOR waiting on tag 5, snooped three cycles later
        sb.push_back(mk(5'd8, 32'hEDCB_A987, 5'b0));
        dispatch(OP_XOR, 32'h0, 32'hFFFF_FFFF, 5'd5, INV);
        cyc(1);
        @(negedge clk); check("t2_wait_req", 32'(bus.out_cdb_req), 0);
        cyc(1);
        cdb(5'd5, 32'h1234_5678);
        @(negedge clk); check("t2_req_early", 32'(bus.out_cdb_req), 0);
        @(negedge clk); check("t2_req_lat2",  32'(bus.out_cdb_req), 1);
        cyc(1);
        drain();

        // Fill all entries on tag 7, drop an extra dispatch, hold grant then release in order
        grant_en = 1'b0;
        sb.push_back(mk(5'd8,  32'h0F0F_00FF, 5'b0));
        sb.push_back(mk(5'd9,  32'h000F_0000, 5'b0));
        sb.push_back(mk(5'd10, 32'h0F0F_FFFF, 5'b0));
        sb.push_back(mk(5'd11, 32'hFFFF_FFFF, 5'b0));
        dispatch(OP_OR,   32'h0, 32'h0000_00FF, 5'd7, INV);
        dispatch(OP_ANDN, 32'h0, 32'h0F00_0000, 5'd7, INV);
        dispatch(OP_ORN,  32'h0, 32'hFFFF_0000, 5'd7, INV);
        dispatch(OP_XNOR, 32'h0, 32'h0F0F_0000, 5'd7, INV);
        @(negedge clk); check("t3_full_ready", 32'(bus.out_rs_ready), 0);
        cyc(1);
        dispatch(OP_AND, 32'h1, 32'h1, INV, INV);
        @(negedge clk);
        check("t3_drop_ready", 32'(bus.out_rs_ready), 0);
        check("t3_drop_req",   32'(bus.out_cdb_req),  0);
        cyc(1);
        cdb(5'd7, 32'h0F0F_0000);
        cyc(5);
        @(negedge clk);
        check("t3_hold_req", 32'(bus.out_cdb_req), 1);
        check("t3_hold_tag", 32'(bus.out_cdb_tag), 8);
        check("t3_hold_val", bus.out_cdb_val,      32'h0F0F_00FF);
        cyc(1);
        grant_en = 1'b1;
        drain();
        @(negedge clk);
        check("t3_after_ready", 32'(bus.out_rs_ready), 1);
        check("t3_after_tag",   32'(bus.out_rs_tag),   8);
        cyc(1);

        // Shifts back to back; third dispatch coincides with grant of entry 0 and takes entry 2
        sb.push_back(mk(5'd8,  32'hF800_0000, 5'b0));
        sb.push_back(mk(5'd9,  32'h0000_0010, 5'b0));
        sb.push_back(mk(5'd10, 32'h0800_0000, 5'b0));
        dispatch(OP_SRA, 32'h8000_0000, 32'd4,  INV, INV);
        dispatch(OP_SLL, 32'h0000_0001, 32'd36, INV, INV);
        dispatch(OP_SRL, 32'h8000_0000, 32'd4,  INV, INV);
        drain();

        // Same-cycle bypass of operand 1 from the CDB
        sb.push_back(mk(5'd8, 32'hA5A5_5A5A, 5'b0));
        bus.in_cdb_valid = 1'b1;
        bus.in_cdb_tag   = 5'd12;
        bus.in_cdb_val   = 32'hA5A5_0000;
        dispatch(OP_OR, 32'h0, 32'h0000_5A5A, 5'd12, INV);
        bus.in_cdb_valid = 1'b0;
        @(negedge clk); check("t5_req_early", 32'(bus.out_cdb_req), 0);
        @(negedge clk); check("t5_req_lat2",  32'(bus.out_cdb_req), 1);
        cyc(1);
        drain();

        // _CC ops: zero result and negative result
        sb.push_back(mk(5'd8, 32'h0000_0000, 5'b1_0010));
        sb.push_back(mk(5'd9, 32'h8000_0000, 5'b1_0001));
        dispatch(OP_ANDCC, 32'hF0F0_F0F0, 32'h0F0F_0F0F, INV, INV);
        dispatch(OP_XORCC, 32'h8000_0000, 32'h0,         INV, INV);
        drain();

        // Unsupported opcode is ignored
        dispatch(OP_BAD, 32'h1, 32'h1, INV, INV);
        @(negedge clk);
        check("bad_ready",  32'(bus.out_rs_ready), 1);
        check("bad_rs_tag", 32'(bus.out_rs_tag),   8);
        cyc(3);
        @(negedge clk); check("bad_req", 32'(bus.out_cdb_req), 0);
        cyc(1);

        // Reset mid-operation drops the waiting entry
        dispatch(OP_AND, 32'h1, 32'h1, 5'd7, INV);
        @(negedge clk); check("mid_busy_tag", 32'(bus.out_rs_tag), 9);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        @(negedge clk);
        check("mid_rst_ready", 32'(bus.out_rs_ready), 1);
        check("mid_rst_tag",   32'(bus.out_rs_tag),   8);
        cyc(1);
        rst = 1'b0;
        cdb(5'd7, 32'h5);
        cyc(3);
        @(negedge clk); check("mid_rst_req", 32'(bus.out_cdb_req), 0);
        check("final_pending", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
